// File: rtl/cordic_sin_quadrant_map.sv
// -----------------------------------------------------------------------------
// cordic_sin_quadrant_map
//
// Wraps a SIN-mode CORDIC core on both sides.
//   Input side : accepts any angle in [-4,4) rad (Q3.13), wraps it into
//                [-pi,pi], folds it into [-pi/2,pi/2] and issues it to the
//                core as a registered start pulse plus a Q2.14 angle.
//   Output side: a tag FIFO remembers, per issued angle, whether the fold
//                flipped the cosine sign; each core result pops one tag, gets
//                its cosine sign restored (saturating) and lands in an output
//                FIFO with a registered head. A credit counter gates in_ready
//                so that every accepted request always has an output slot.
//
// Parameters
//   DEPTH          max transactions in flight; power of 2, 4..64
//
// Ports
//   clk            clock (single domain)
//   rst            synchronous active-high reset; also drives the core's rst
//   in_valid       angle request valid
//   in_ready       request accepted when in_valid & in_ready
//   in_angle_q13   signed angle, rad, Q3.13
//   core_start     registered start pulse to the core
//   core_angle_q14 registered folded angle to the core, Q2.14
//   core_result    core sin, Q2.14
//   core_secondary core cos, Q2.14
//   core_valid     core result strobe (one cycle per start)
//   out_valid      output FIFO head valid
//   out_ready      consumer accepts when out_valid & out_ready
//   out_sin_q14    sin(in_angle), Q2.14
//   out_cos_q14    cos(in_angle), Q2.14
//   err_underflow  sticky protocol error flag
//
// Build option
//   CORDIC_QMAP_ERR_EN  when defined, err_underflow latches on a core_valid
//                       with an empty tag FIFO or a tag push into a full tag
//                       FIFO. When undefined, err_underflow is tied low.
// -----------------------------------------------------------------------------
module cordic_sin_quadrant_map #(
   parameter int DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_angle_q13,
   output logic        core_start,
   output logic [15:0] core_angle_q14,
   input  logic [15:0] core_result,
   input  logic [15:0] core_secondary,
   input  logic        core_valid,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_sin_q14,
   output logic [15:0] out_cos_q14,
   output logic        err_underflow
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int PTR_W = $clog2(DEPTH);

   // Angle constants in Q3.13, widened to 17 bits so wrap arithmetic on a
   // full-range 16-bit input never overflows.
   localparam logic signed [16:0] PI      = 17'sd25736;
   localparam logic signed [16:0] TWO_PI  = 17'sd51472;
   localparam logic signed [16:0] HALF_PI = 17'sd12868;

   // ---------------------------------------------------------------------------
   // Credits: one credit per accepted request, returned on output handshake.
   // ---------------------------------------------------------------------------
   logic [CNT_W-1:0] credit_cnt;
   logic             accept;
   logic             out_fire;

   assign in_ready = !rst && (credit_cnt < CNT_W'(DEPTH));
   assign accept   = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         credit_cnt <= '0;
      end else if (accept && !out_fire) begin
         credit_cnt <= credit_cnt + CNT_W'(1);
      end else if (!accept && out_fire) begin
         credit_cnt <= credit_cnt - CNT_W'(1);
      end
   end

   // ---------------------------------------------------------------------------
   // S1: wrap into [-pi, pi]
   // ---------------------------------------------------------------------------
   logic signed [16:0] in_ext;
   logic signed [16:0] wrap_angle;
   logic signed [16:0] s1_angle;
   logic               s1_valid;

   always_comb begin
      in_ext     = {in_angle_q13[15], in_angle_q13};
      wrap_angle = in_ext;
      if (in_ext > PI) begin
         wrap_angle = in_ext - TWO_PI;
      end else if (in_ext < -PI) begin
         wrap_angle = in_ext + TWO_PI;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_angle <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_angle <= wrap_angle;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // S2: fold into [-pi/2, pi/2] and drive the core
   // ---------------------------------------------------------------------------
   logic signed [16:0] fold_full;
   logic        [15:0] fold_angle;
   logic               fold_neg;

   // Folding about +/-pi/2 keeps sin and flips the sign of cos; the flip is
   // carried to the output side as a one-bit tag.
   always_comb begin
      fold_full = s1_angle;
      fold_neg  = 1'b0;
      if (s1_angle > HALF_PI) begin
         fold_full = PI - s1_angle;
         fold_neg  = 1'b1;
      end else if (s1_angle < -HALF_PI) begin
         fold_full = -PI - s1_angle;
         fold_neg  = 1'b1;
      end
      // |fold_full| <= pi/2, so the Q3.13 value and its Q2.14 doubling fit in 16 bits.
      fold_angle = 16'(fold_full);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         core_start     <= 1'b0;
         core_angle_q14 <= '0;
      end else begin
         core_start <= s1_valid;
         if (s1_valid) begin
            core_angle_q14 <= fold_angle << 1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Tag FIFO: one cos-sign bit per issued start
   // ---------------------------------------------------------------------------
   logic             tag_mem [DEPTH];
   logic [CNT_W-1:0] tag_wr_ptr;
   logic [CNT_W-1:0] tag_rd_ptr;
   logic             tag_push;
   logic             tag_pop;
   logic             tag_empty;
   logic             tag_neg;

   assign tag_push  = s1_valid;
   assign tag_empty = (tag_wr_ptr == tag_rd_ptr);
   assign tag_pop   = core_valid && !tag_empty;
   // A result with no matching tag is passed through unnegated.
   assign tag_neg   = tag_pop ? tag_mem[tag_rd_ptr[PTR_W-1:0]] : 1'b0;

   always_ff @(posedge clk) begin
      if (rst) begin
         tag_wr_ptr <= '0;
         tag_rd_ptr <= '0;
      end else begin
         if (tag_push) tag_wr_ptr <= tag_wr_ptr + CNT_W'(1);
         if (tag_pop)  tag_rd_ptr <= tag_rd_ptr + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (tag_push) begin
         tag_mem[tag_wr_ptr[PTR_W-1:0]] <= fold_neg;
      end
   end

   // ---------------------------------------------------------------------------
   // Result sign restore (saturating negate: -(-32768) -> 32767)
   // ---------------------------------------------------------------------------
   logic [15:0] cos_negated;
   logic [15:0] wr_cos;

   always_comb begin
      if (core_secondary == 16'h8000) begin
         cos_negated = 16'h7FFF;
      end else begin
         cos_negated = 16'h0000 - core_secondary;
      end
      wr_cos = tag_neg ? cos_negated : core_secondary;
   end

   // ---------------------------------------------------------------------------
   // Output FIFO: storage ring plus a registered head (out_* registers)
   // ---------------------------------------------------------------------------
   logic [31:0]      ofifo_mem [DEPTH];
   logic [CNT_W-1:0] ofifo_wr_ptr;
   logic [CNT_W-1:0] ofifo_rd_ptr;
   logic             ofifo_empty;
   logic             head_load;
   logic             head_bypass;
   logic             ofifo_write;
   logic             ofifo_read;

   // The head refills whenever it is empty or being consumed. Older entries in
   // the ring take priority; an incoming result skips the ring only when the
   // ring is empty, which keeps ordering intact at any occupancy.
   assign ofifo_empty = (ofifo_wr_ptr == ofifo_rd_ptr);
   assign head_load   = !out_valid || out_fire;
   assign ofifo_read  = head_load && !ofifo_empty;
   assign head_bypass = head_load && ofifo_empty && core_valid;
   assign ofifo_write = core_valid && !head_bypass;

   always_ff @(posedge clk) begin
      if (rst) begin
         ofifo_wr_ptr <= '0;
         ofifo_rd_ptr <= '0;
         out_valid    <= 1'b0;
         out_sin_q14  <= '0;
         out_cos_q14  <= '0;
      end else begin
         if (ofifo_write) ofifo_wr_ptr <= ofifo_wr_ptr + CNT_W'(1);
         if (ofifo_read)  ofifo_rd_ptr <= ofifo_rd_ptr + CNT_W'(1);
         if (head_load) begin
            if (ofifo_read) begin
               {out_sin_q14, out_cos_q14} <= ofifo_mem[ofifo_rd_ptr[PTR_W-1:0]];
               out_valid                  <= 1'b1;
            end else if (head_bypass) begin
               out_sin_q14 <= core_result;
               out_cos_q14 <= wr_cos;
               out_valid   <= 1'b1;
            end else begin
               out_valid <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (ofifo_write) begin
         ofifo_mem[ofifo_wr_ptr[PTR_W-1:0]] <= {core_result, wr_cos};
      end
   end

   // ---------------------------------------------------------------------------
   // Protocol error flag
   // ---------------------------------------------------------------------------
`ifdef CORDIC_QMAP_ERR_EN
   logic tag_full;

   assign tag_full = (tag_wr_ptr[PTR_W-1:0] == tag_rd_ptr[PTR_W-1:0]) &&
                     (tag_wr_ptr[PTR_W] != tag_rd_ptr[PTR_W]);

   always_ff @(posedge clk) begin
      if (rst) begin
         err_underflow <= 1'b0;
      end else if ((core_valid && tag_empty) || (tag_push && tag_full)) begin
         err_underflow <= 1'b1;
      end
   end
`else
   assign err_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_sin_quadrant_map.sv
module tb_cordic_sin_quadrant_map;

   localparam int DEPTH = 16;
   localparam int LAT   = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_angle_q13 = '0;
   logic        core_start;
   logic [15:0] core_angle_q14;
   logic [15:0] core_result = '0;
   logic [15:0] core_secondary = '0;
   logic        core_valid = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_sin_q14;
   logic [15:0] out_cos_q14;
   logic        err_underflow;

   cordic_sin_quadrant_map #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_angle_q13(in_angle_q13),
      .core_start(core_start), .core_angle_q14(core_angle_q14),
      .core_result(core_result), .core_secondary(core_secondary), .core_valid(core_valid),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sin_q14(out_sin_q14), .out_cos_q14(out_cos_q14),
      .err_underflow(err_underflow)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic [15:0] s; logic [15:0] c; } res_t;
   typedef struct { logic [15:0] ang; int due; } core_t;

   res_t        exp_q[$];
   logic [15:0] pending[$];
   core_t       core_q[$];
   int n_checks = 0;
   int n_fail   = 0;
   int accepted = 0;
   int outputs  = 0;
   int cyc      = 0;
   int valid_pct = 100;
   bit inject   = 1'b0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Stand-in core: sin output echoes the angle, cos output flips its MSB.
   // Injective, so a wrong core angle shows up in both outputs, and angle 0
   // yields cos = -32768 to exercise the saturating negate.
   function automatic logic [15:0] core_sin(input logic [15:0] x);
      return x;
   endfunction
   function automatic logic [15:0] core_cos(input logic [15:0] x);
      return x ^ 16'h8000;
   endfunction

   // Reference: reduce the angle into [-pi,pi], reflect into [-pi/2,pi/2],
   // and predict the core's outputs with the cos sign restored.
   function automatic res_t ref_model(input logic [15:0] ang);
      int a, f, c, n;
      bit neg;
      logic [15:0] x;
      res_t r;
      a = int'($signed(ang));
      if (a > 25736)  a = a - 51472;
      if (a < -25736) a = a + 51472;
      neg = 1'b0;
      f   = a;
      if (a > 12868) begin
         f = 25736 - a;  neg = 1'b1;
      end else if (a < -12868) begin
         f = -25736 - a; neg = 1'b1;
      end
      x = 16'(f * 2);
      c = int'($signed(core_cos(x)));
      n = neg ? -c : c;
      if (n > 32767) n = 32767;
      r.s = core_sin(x);
      r.c = 16'(n);
      return r;
   endfunction

   // Request driver
   initial forever begin
      @(posedge clk);
      #1;
      if (pending.size() > 0 && $urandom_range(0, 99) < valid_pct) begin
         in_valid     = 1'b1;
         in_angle_q13 = pending[0];
      end else begin
         in_valid = 1'b0;
      end
   end

   // Core model
   initial forever begin
      core_t c;
      @(negedge clk);
      if (rst) begin
         core_q.delete();
         core_valid = 1'b0;
      end else begin
         core_valid = 1'b0;
         if (core_q.size() > 0 && core_q[0].due <= cyc) begin
            c = core_q.pop_front();
            core_valid     = 1'b1;
            core_result    = core_sin(c.ang);
            core_secondary = core_cos(c.ang);
         end else if (inject) begin
            inject         = 1'b0;
            core_valid     = 1'b1;
            core_result    = core_sin(16'h1234);
            core_secondary = core_cos(16'h1234);
            exp_q.push_back({core_sin(16'h1234), core_cos(16'h1234)});
         end
         if (core_start) core_q.push_back('{core_angle_q14, cyc + LAT});
      end
   end

   // Scoreboard: push on accept, pop and compare on output handshake
   initial forever begin
      res_t e;
      @(negedge clk);
      if (!rst) begin
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_model(in_angle_q13));
            if (pending.size() > 0) void'(pending.pop_front());
            accepted++;
         end
         if (out_valid && out_ready) begin
            outputs++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_output: got %h%h expected none", out_sin_q14, out_cos_q14);
            end else begin
               e = exp_q.pop_front();
               check("out_sin_cos", {out_sin_q14, out_cos_q14}, {e.s, e.c});
            end
         end
      end
   end

   task automatic wait_drain(input int budget, input bit rand_ready);
      for (int i = 0; i < budget && (pending.size() > 0 || exp_q.size() > 0); i++) begin
         @(posedge clk);
         #1;
         out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      out_ready = 1'b1;
      check("drain_left", 32'(pending.size() + exp_q.size()), 32'd0);
   endtask

   initial begin
      int base;
      int obase;
      logic [15:0] directed [14];
      directed = '{16'h0000, 16'h4000, 16'h7000, 16'hC000, 16'h3244, 16'h6488, 16'h9B78,
                   16'h6489, 16'h7FFF, 16'h8000, 16'hCDBC, 16'hCDBB, 16'h3245, 16'h9B77};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready",   32'(in_ready),       32'd0);
      check("rst_out_valid",  32'(out_valid),      32'd0);
      check("rst_core_start", 32'(core_start),     32'd0);
      check("rst_core_angle", 32'(core_angle_q14), 32'd0);
      check("rst_out_sin",    32'(out_sin_q14),    32'd0);
      check("rst_out_cos",    32'(out_cos_q14),    32'd0);
      check("rst_err",        32'(err_underflow),  32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", 32'(in_ready), 32'd1);

      // Directed angles including wrap / fold boundaries
      @(posedge clk);
      #1 out_ready = 1'b1;
      foreach (directed[i]) pending.push_back(directed[i]);
      wait_drain(1000, 1'b0);

      // Randomized traffic with random gaps and backpressure
      valid_pct = 70;
      for (int i = 0; i < 300; i++) pending.push_back(16'($urandom));
      wait_drain(5000, 1'b1);
      valid_pct = 100;

      // Full credit backpressure
      @(posedge clk);
      #1 out_ready = 1'b0;
      base = accepted;
      for (int i = 0; i < 20; i++) pending.push_back(16'($urandom));
      repeat (60) @(posedge clk);
      @(negedge clk);
      check("bp_accepted",  32'(accepted - base), 32'd16);
      check("bp_in_ready",  32'(in_ready),        32'd0);
      check("bp_out_valid", 32'(out_valid),       32'd1);
      @(posedge clk);
      #1 out_ready = 1'b1;
      wait_drain(1000, 1'b0);
      check("bp_accepted_all", 32'(accepted - base), 32'd20);

      // Mid-operation reset with work in flight
      @(posedge clk);
      #1 out_ready = 1'b0;
      base = accepted;
      for (int i = 0; i < 5; i++) pending.push_back(16'($urandom));
      for (int i = 0; i < 100 && accepted - base < 5; i++) @(posedge clk);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      pending.delete();
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_out_valid",  32'(out_valid),  32'd0);
      check("mid_rst_core_start", 32'(core_start), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      out_ready = 1'b1;
      obase = outputs;
      pending.push_back(16'h2000);
      wait_drain(1000, 1'b0);
      repeat (30) @(posedge clk);
      @(negedge clk);
      check("post_rst_outputs", 32'(outputs - obase), 32'd1);

`ifdef CORDIC_QMAP_ERR_EN
      check("err_idle", 32'(err_underflow), 32'd0);
      @(posedge clk);
      #1 inject = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("err_set", 32'(err_underflow), 32'd1);
      wait_drain(200, 1'b0);
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("err_sticky", 32'(err_underflow), 32'd1);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("err_cleared", 32'(err_underflow), 32'd0);
`else
      check("err_tied_low", 32'(err_underflow), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

endmodule
